// File: rtl/img_pkg.sv
// Shared image-SRAM types for the RX and TX controllers.
package img_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned COORD_W = 8;

  typedef logic [DATA_W-1:0]  pixel_t;
  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/img_sram_intf.sv
// Single-port image SRAM interface; the controller side is the master.
interface img_sram_intf
  import img_pkg::*;
(
  input logic clk
);

  coord_t row;
  coord_t col;
  pixel_t din;
  logic   write_en;
  logic   sense_en;

  modport mst (input clk, output row, col, din, write_en, sense_en);
  modport slv (input clk, row, col, din, write_en, sense_en);

endinterface

// File: rtl/io_rx_addr_gen.sv
// Row-major raster counter over an nrows x ncols frame.
module io_rx_addr_gen
  import img_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clr,
  input  logic   inc,
  input  coord_t nrows,
  input  coord_t ncols,
  output coord_t row,
  output coord_t col,
  output logic   last_c
);

  coord_t row_q, row_d;
  coord_t col_q, col_d;
  coord_t nrows_m1;
  coord_t ncols_m1;

  assign nrows_m1 = nrows - coord_t'(1);
  assign ncols_m1 = ncols - coord_t'(1);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (inc) begin
      if (col_q == ncols_m1) begin
        col_d = '0;
        row_d = row_q + coord_t'(1);
      end else begin
        col_d = col_q + coord_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row    = row_q;
  assign col    = col_q;
  assign last_c = (row_q == nrows_m1) && (col_q == ncols_m1);

endmodule

// File: rtl/io_rx_controller.sv
// Streams a valid/ready pixel flow into the image SRAM in raster order.
module io_rx_controller
  import img_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  coord_t nrows,
  input  coord_t ncols,
  input  pixel_t din,
  input  logic   din_valid,
  output logic   din_ready,
  output logic   busy,
  output logic   done,
  img_sram_intf.mst sram_img
);

  rx_state_e state_q, state_d;
  coord_t    nrows_q, nrows_d;
  coord_t    ncols_q, ncols_d;
  logic      wr_pend_q, wr_pend_d;
  coord_t    wr_row_q, wr_row_d;
  coord_t    wr_col_q, wr_col_d;
  pixel_t    wr_data_q, wr_data_d;
  logic      din_ready_q, din_ready_d;
  logic      busy_q, busy_d;
  logic      done_q, done_d;

  logic   cnt_clr;
  logic   cnt_inc;
  coord_t cnt_row;
  coord_t cnt_col;
  logic   cnt_last_c;

  io_rx_addr_gen u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .nrows  (nrows_q),
    .ncols  (ncols_q),
    .row    (cnt_row),
    .col    (cnt_col),
    .last_c (cnt_last_c)
  );

  // Next state, dimension latch and write-stage capture.
  always_comb begin
    state_d   = state_q;
    nrows_d   = nrows_q;
    ncols_d   = ncols_q;
    wr_pend_d = 1'b0;
    wr_row_d  = wr_row_q;
    wr_col_d  = wr_col_q;
    wr_data_d = wr_data_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          nrows_d = nrows;
          ncols_d = ncols;
          cnt_clr = 1'b1;
          state_d = ((nrows == '0) || (ncols == '0)) ? DONE : RECV;
        end
      end
      RECV: begin
        if (din_valid) begin
          wr_pend_d = 1'b1;
          wr_row_d  = cnt_row;
          wr_col_d  = cnt_col;
          wr_data_d = din;
          cnt_inc   = 1'b1;
          if (cnt_last_c) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status outputs are registered copies of the upcoming state.
    din_ready_d = (state_d == RECV);
    busy_d      = (state_d == RECV) || (state_d == FLUSH);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      nrows_q     <= '0;
      ncols_q     <= '0;
      wr_pend_q   <= 1'b0;
      wr_row_q    <= '0;
      wr_col_q    <= '0;
      wr_data_q   <= '0;
      din_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      nrows_q     <= nrows_d;
      ncols_q     <= ncols_d;
      wr_pend_q   <= wr_pend_d;
      wr_row_q    <= wr_row_d;
      wr_col_q    <= wr_col_d;
      wr_data_q   <= wr_data_d;
      din_ready_q <= din_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign din_ready = din_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

  assign sram_img.row      = wr_row_q;
  assign sram_img.col      = wr_col_q;
  assign sram_img.din      = wr_data_q;
  assign sram_img.write_en = wr_pend_q;
  assign sram_img.sense_en = 1'b1;

endmodule

// File: tb/tb_io_rx_controller.sv
// Directed bench for io_rx_controller: frame writes, bubbles, empty frames, abort.
module tb_io_rx_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] nrows;
  logic [7:0] ncols;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       busy;
  logic       done;

  int n_chk;
  int n_err;
  int wr_count;
  logic [7:0] mem [256][256];

  img_sram_intf sram_if (.clk(clk));

  io_rx_controller dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .nrows     (nrows),
    .ncols     (ncols),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .busy      (busy),
    .done      (done),
    .sram_img  (sram_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model and write counter.
  always @(posedge clk) begin
    if (sram_if.write_en === 1'b1) begin
      mem[sram_if.row][sram_if.col] <= sram_if.din;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int nr, input int nc, input int mode,
                           input logic [7:0] base, input bit disturb);
    int total;
    int k;
    int cyc;
    logic v;
    total     = nr * nc;
    wr_count  = 0;
    nrows     = 8'(nr);
    ncols     = 8'(nc);
    start     = 1'b1;
    din_valid = 1'b0;
    step();
    start = 1'b0;
    if (total == 0) begin
      check("empty_done", 32'(done), 32'd1);
      check("empty_busy", 32'(busy), 32'd0);
      check("empty_ready", 32'(din_ready), 32'd0);
      check("empty_wen", 32'(sram_if.write_en), 32'd0);
      step();
      check("empty_done_clr", 32'(done), 32'd0);
      check("empty_wr_count", 32'(wr_count), 32'd0);
      return;
    end
    check("start_ready", 32'(din_ready), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    k   = 0;
    cyc = 0;
    while (k < total && cyc < total * 4 + 64) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 15) != 0);
      endcase
      if (disturb && cyc == 2) begin
        start = 1'b1;
        nrows = 8'd1;
        ncols = 8'd1;
      end
      din       = base + 8'(k);
      din_valid = v;
      step();
      start = 1'b0;
      nrows = 8'(nr);
      ncols = 8'(nc);
      if (v) begin
        check("wr_en", 32'(sram_if.write_en), 32'd1);
        check("wr_row", 32'(sram_if.row), 32'(k / nc));
        check("wr_col", 32'(sram_if.col), 32'(k % nc));
        check("wr_data", 32'(sram_if.din), 32'(8'(base + 8'(k))));
        k++;
      end else begin
        check("bubble_wen", 32'(sram_if.write_en), 32'd0);
      end
      if (k < total) begin
        check("recv_ready", 32'(din_ready), 32'd1);
        check("recv_done", 32'(done), 32'd0);
      end
      cyc++;
    end
    if (k < total) check("frame_timeout", 32'(k), 32'(total));
    // Valid beats offered outside RECV must not be taken.
    din_valid = 1'b1;
    din       = 8'hee;
    check("flush_ready", 32'(din_ready), 32'd0);
    check("flush_busy", 32'(busy), 32'd1);
    check("flush_done", 32'(done), 32'd0);
    step();
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_wen", 32'(sram_if.write_en), 32'd0);
    check("done_ready", 32'(din_ready), 32'd0);
    step();
    check("done_clr", 32'(done), 32'd0);
    check("idle_wen", 32'(sram_if.write_en), 32'd0);
    check("idle_ready", 32'(din_ready), 32'd0);
    step();
    check("idle_wen2", 32'(sram_if.write_en), 32'd0);
    din_valid = 1'b0;
    check("wr_count", 32'(wr_count), 32'(total));
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    wr_count  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    nrows     = '0;
    ncols     = '0;
    din       = '0;
    din_valid = 1'b0;
    step();
    step();
    check("rst_ready", 32'(din_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wen", 32'(sram_if.write_en), 32'd0);
    check("rst_row", 32'(sram_if.row), 32'd0);
    check("rst_col", 32'(sram_if.col), 32'd0);
    check("rst_sense", 32'(sram_if.sense_en), 32'd1);
    rst = 1'b0;
    step();

    // 2x3 frame, back-to-back pixels.
    run_frame(2, 3, 0, 8'h10, 1'b0);

    // 2x2 frame, alternating valid; then SRAM contents in stream order.
    run_frame(2, 2, 1, 8'h40, 1'b0);
    check("mem_00", 32'(mem[0][0]), 32'h40);
    check("mem_01", 32'(mem[0][1]), 32'h41);
    check("mem_10", 32'(mem[1][0]), 32'h42);
    check("mem_11", 32'(mem[1][1]), 32'h43);

    // Empty frames.
    run_frame(0, 5, 0, 8'h00, 1'b0);
    run_frame(4, 0, 0, 8'h00, 1'b0);

    // Abort a 3x3 frame after its third pixel.
    nrows = 8'd3;
    ncols = 8'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din       = 8'(8'h80 + 8'(i));
      din_valid = 1'b1;
      step();
    end
    check("abort_pre_wen", 32'(sram_if.write_en), 32'd1);
    check("abort_pre_col", 32'(sram_if.col), 32'd2);
    rst = 1'b1;
    step();
    rst       = 1'b0;
    din_valid = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wen", 32'(sram_if.write_en), 32'd0);
    check("abort_ready", 32'(din_ready), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_no_done", 32'(done), 32'd0);
    end
    run_frame(2, 2, 0, 8'h90, 1'b0);

    // Start pulsed mid-frame with other dimensions is ignored.
    run_frame(3, 2, 0, 8'h20, 1'b1);

    // Largest frame with random valid gaps.
    run_frame(255, 255, 2, 8'h00, 1'b0);
    check("max_last", 32'(mem[254][254]), 32'(8'(65024)));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
